// File: rtl/core_exec_pkg.sv
// Shared encodings for the execute stage: ALU op codes and FSM state codes.
package core_exec_pkg;

  // ALU operation encodings (alu_op)
  localparam logic [3:0] EXOP_ADD  = 4'd0;
  localparam logic [3:0] EXOP_SUB  = 4'd1;
  localparam logic [3:0] EXOP_AND  = 4'd2;
  localparam logic [3:0] EXOP_OR   = 4'd3;
  localparam logic [3:0] EXOP_XOR  = 4'd4;
  localparam logic [3:0] EXOP_SLL  = 4'd5;
  localparam logic [3:0] EXOP_SRL  = 4'd6;
  localparam logic [3:0] EXOP_SRA  = 4'd7;
  localparam logic [3:0] EXOP_SLT  = 4'd8;
  localparam logic [3:0] EXOP_SLTU = 4'd9;
  localparam logic [3:0] EXOP_MUL  = 4'd10;

  // Execute FSM state encodings
  localparam logic [1:0] EX_ST_IDLE = 2'd0;
  localparam logic [1:0] EX_ST_MUL  = 2'd1;
  localparam logic [1:0] EX_ST_OUT  = 2'd2;

endpackage

// File: rtl/core_exec_mul.sv
// Iterative radix-2 shift-add multiplier: WIDTH iterations after start, low word only.
// done_o is asserted during the final iteration; product_o is valid in that same cycle.
module core_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [CntW-1:0]  cnt_q;
  logic             active_q;

  // Accumulate the shifted multiplicand when the current multiplier bit is set
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) acc_d = acc_q + mcand_q;
  end

  assign done_o    = active_q && (cnt_q == CntW'(WIDTH - 1));
  assign product_o = acc_d;

  // Load operands on start, then shift one multiplier bit per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_d;
      cnt_q    <= cnt_q + 1'b1;
      if (done_o) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/core_exec.sv
// Execute stage: single-cycle ALU with registered result/flags and a one-cycle valid pulse.
// Optional iterative multiplier enabled by defining I2D_EX_MUL_EN; otherwise MUL is an
// undefined op (one cycle, result 0, flags 0).
module core_exec
  import core_exec_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OP_W-1:0]  alu_op_i,
  input  logic             in_valid_i,
  input  logic             stall_in_i,
  output logic             busy_o,
  output logic [WIDTH-1:0] result_o,
  output logic             out_valid_o,
  output logic             flag_z_o,
  output logic             flag_c_o
);

  localparam int unsigned ShW = $clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             z_q, z_d, c_q, c_d;

  logic             accept, is_mul, mul_start, mul_done;
  logic [WIDTH-1:0] mul_product;

  logic [WIDTH:0]   sum, diff;
  logic [ShW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_ok;

  assign out_valid_o = (state_q == EX_ST_OUT);
  assign busy_o      = (state_q == EX_ST_MUL) | (out_valid_o & stall_in_i);
  assign accept      = in_valid_i & ~busy_o & ~stall_in_i;
  assign result_o    = result_q;
  assign flag_z_o    = z_q;
  assign flag_c_o    = c_q;

`ifdef I2D_EX_MUL_EN
  assign is_mul = (alu_op_i == OP_W'(EXOP_MUL));

  core_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start_i  (mul_start),
    .a_i      (a_i),
    .b_i      (b_i),
    .done_o   (mul_done),
    .product_o(mul_product)
  );
`else
  assign is_mul      = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  // Single-cycle ALU; carry is bit WIDTH of the (WIDTH+1)-bit add/subtract
  always_comb begin
    sum     = {1'b0, a_i} + {1'b0, b_i};
    diff    = {1'b0, a_i} + {1'b0, ~b_i} + 1'b1;
    shamt   = b_i[ShW-1:0];
    alu_res = '0;
    alu_c   = 1'b0;
    alu_ok  = 1'b1;
    case (alu_op_i)
      OP_W'(EXOP_ADD):  begin alu_res = sum[WIDTH-1:0];  alu_c = sum[WIDTH];  end
      OP_W'(EXOP_SUB):  begin alu_res = diff[WIDTH-1:0]; alu_c = diff[WIDTH]; end
      OP_W'(EXOP_AND):  alu_res = a_i & b_i;
      OP_W'(EXOP_OR):   alu_res = a_i | b_i;
      OP_W'(EXOP_XOR):  alu_res = a_i ^ b_i;
      OP_W'(EXOP_SLL):  alu_res = a_i << shamt;
      OP_W'(EXOP_SRL):  alu_res = a_i >> shamt;
      OP_W'(EXOP_SRA):  alu_res = $unsigned($signed(a_i) >>> shamt);
      OP_W'(EXOP_SLT):  alu_res = {{(WIDTH-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      OP_W'(EXOP_SLTU): alu_res = {{(WIDTH-1){1'b0}}, a_i < b_i};
      default:          alu_ok  = 1'b0;
    endcase
  end

  // FSM next state and output register updates; OUT holds everything while stalled
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    z_d       = z_q;
    c_d       = c_q;
    mul_start = 1'b0;
    case (state_q)
      EX_ST_IDLE, EX_ST_OUT: begin
        if (state_q == EX_ST_OUT && !stall_in_i) state_d = EX_ST_IDLE;
        if (accept) begin
          if (is_mul) begin
            state_d   = EX_ST_MUL;
            mul_start = 1'b1;
          end else begin
            state_d  = EX_ST_OUT;
            result_d = alu_res;
            z_d      = alu_ok && (alu_res == '0);
            c_d      = alu_c;
          end
        end
      end
      EX_ST_MUL: begin
        if (mul_done) begin
          state_d  = EX_ST_OUT;
          result_d = mul_product;
          z_d      = (mul_product == '0);
          c_d      = 1'b0;
        end
      end
      default: state_d = EX_ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EX_ST_IDLE;
      result_q <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      z_q      <= z_d;
      c_q      <= c_d;
    end
  end

endmodule

// File: tb/tb_core_exec.sv
// Directed self-checking bench for core_exec. MUL checks adapt to I2D_EX_MUL_EN.
module tb_core_exec;
  import core_exec_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic [3:0]  alu_op;
  logic        in_valid, stall_in;
  logic        busy, out_valid, flag_z, flag_c;
  logic [31:0] result;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  core_exec #(
    .WIDTH(32),
    .OP_W (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .a_i        (a),
    .b_i        (b),
    .alu_op_i   (alu_op),
    .in_valid_i (in_valid),
    .stall_in_i (stall_in),
    .busy_o     (busy),
    .result_o   (result),
    .out_valid_o(out_valid),
    .flag_z_o   (flag_z),
    .flag_c_o   (flag_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one op for exactly one edge, sample #1 after that edge
  task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
    alu_op = op; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_alu(input string tag, input logic [3:0] op, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] er, input logic ez,
                         input logic ec);
    issue(op, av, bv);
    check({tag, ".res"}, result, er);
    check({tag, ".z"}, 32'(flag_z), 32'(ez));
    check({tag, ".c"}, 32'(flag_c), 32'(ec));
    check({tag, ".ov"}, 32'(out_valid), 32'd1);
  endtask

  int n, ov_seen;

  initial begin
    rst = 1'b1; a = '0; b = '0; alu_op = '0; in_valid = 1'b0; stall_in = 1'b0;
    #1;
    check("rst.res", result, 32'd0);
    check("rst.ov", 32'(out_valid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.z", 32'(flag_z), 32'd0);
    check("rst.c", 32'(flag_c), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // ADD with one-cycle latency and a single valid pulse
    run_alu("add5_7", EXOP_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    check("add5_7.busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("add5_7.ov_drop", 32'(out_valid), 32'd0);
    check("add5_7.hold", result, 32'd12);

    // Back-to-back SUBs: one result per cycle
    alu_op = EXOP_SUB; a = 32'd0; b = 32'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    check("sub0_1.res", result, 32'hFFFF_FFFF);
    check("sub0_1.c", 32'(flag_c), 32'd0);
    check("sub0_1.ov", 32'(out_valid), 32'd1);
    a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("sub9_9.res", result, 32'd0);
    check("sub9_9.z", 32'(flag_z), 32'd1);
    check("sub9_9.c", 32'(flag_c), 32'd1);
    check("sub9_9.ov", 32'(out_valid), 32'd1);

    run_alu("add_wrap", EXOP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b1);
    run_alu("and", EXOP_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0, 1'b0);
    run_alu("or", EXOP_OR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 1'b0, 1'b0);
    run_alu("xor", EXOP_XOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 1'b0, 1'b0);
    run_alu("sll", EXOP_SLL, 32'd1, 32'h24, 32'h10, 1'b0, 1'b0);
    run_alu("srl", EXOP_SRL, 32'h8000_0000, 32'h1F, 32'd1, 1'b0, 1'b0);
    run_alu("sra", EXOP_SRA, 32'h8000_0000, 32'h21, 32'hC000_0000, 1'b0, 1'b0);
    run_alu("slt", EXOP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    run_alu("sltu", EXOP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    run_alu("undef", 4'hF, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0);

`ifdef I2D_EX_MUL_EN
    // MUL: busy for 32 cycles, a presented ADD is held off until busy drops
    issue(EXOP_MUL, 32'd3, 32'hFFFF_FFFE);
    alu_op = EXOP_ADD; a = 32'd100; b = 32'd1; in_valid = 1'b1;
    n = 0; ov_seen = 0;
    while (busy && n < 40) begin
      if (out_valid) ov_seen++;
      @(posedge clk); #1;
      n++;
    end
    check("mul.busy_cycles", 32'(n), 32'd32);
    check("mul.no_early_ov", 32'(ov_seen), 32'd0);
    check("mul.res", result, 32'hFFFF_FFFA);
    check("mul.ov", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mul.add_after", result, 32'd101);
    check("mul.add_ov", 32'(out_valid), 32'd1);
`else
    run_alu("mul_undef", EXOP_MUL, 32'd3, 32'hFFFF_FFFE, 32'd0, 1'b0, 1'b0);
    check("mul_undef.busy", 32'(busy), 32'd0);
`endif

    // Stall: outputs frozen, busy high, new op ignored until stall drops
    run_alu("stall_add", EXOP_ADD, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0);
    stall_in = 1'b1;
    alu_op = EXOP_ADD; a = 32'd1; b = 32'd1; in_valid = 1'b1;
    #1;
    check("stall.busy0", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall.res", result, 32'd30);
      check("stall.ov", 32'(out_valid), 32'd1);
      check("stall.busy", 32'(busy), 32'd1);
    end
    stall_in = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("unstall.res", result, 32'd2);
    check("unstall.ov", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    check("unstall.ov_drop", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-operation clears outputs immediately
`ifdef I2D_EX_MUL_EN
    issue(EXOP_MUL, 32'd3, 32'd5);
    repeat (10) @(posedge clk);
`else
    issue(EXOP_ADD, 32'd3, 32'd4);
    repeat (3) @(posedge clk);
`endif
    #2 rst = 1'b1;
    #1;
    check("arst.res", result, 32'd0);
    check("arst.ov", 32'(out_valid), 32'd0);
    check("arst.busy", 32'(busy), 32'd0);
    check("arst.z", 32'(flag_z), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    ov_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) ov_seen++;
    end
    check("arst.no_ov", 32'(ov_seen), 32'd0);
    run_alu("arst_add", EXOP_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
